// File: rtl/dtt_xbar_pkg.sv
// Shared definitions for the crossbar and its per-output egress buffers.
//   DTT_DATA_WIDTH   : crossbar word width, shared by crossbar and egress buffer.
//   DTT_LEVEL_W      : width of the level field carried in egress_status_t.
//   egress_status_t  : fill-level status bundle {level, full, empty}.
//   sat_inc()        : saturating increment, used for the drop counter.
package dtt_xbar_pkg;

    localparam int unsigned DTT_DATA_WIDTH = 32;

    // Wide enough for any practical DEPTH; consumers truncate to their own width.
    localparam int unsigned DTT_LEVEL_W = 16;

    typedef struct packed {
        logic [DTT_LEVEL_W-1:0] level;
        logic                   full;
        logic                   empty;
    } egress_status_t;

    // Increment val, but never past max_val. Counters up to 32 bits wide are
    // zero-extended in and truncated back out by the caller.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/dtt_xbar_egress_buffer_if.sv
// Data-path bundle for one crossbar egress buffer.
//   xb_data/xb_valid : word from the crossbar output; no ready is returned.
//   m_data/m_valid   : head-of-FIFO word presented to the consumer.
//   m_ready          : consumer accepts the head word this cycle.
// Modports:
//   master : environment side (drives crossbar word and m_ready).
//   slave  : the egress buffer itself.
interface dtt_xbar_egress_buffer_if
    import dtt_xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DTT_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] xb_data;
    logic                  xb_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output xb_data,
        output xb_valid,
        output m_ready,
        input  m_data,
        input  m_valid
    );

    modport slave (
        input  xb_data,
        input  xb_valid,
        input  m_ready,
        output m_data,
        output m_valid
    );

endinterface

// File: rtl/dtt_xbar_egress_buffer.sv
// Per-output egress buffer downstream of the crossbar switch.
// Absorbs at most one crossbar word per cycle into a synchronous FIFO and
// drains it over a valid/ready handshake. Words arriving while full (and not
// popping) are dropped and counted in a saturating counter.
// Ports:
//   clk        : clock, rising edge.
//   rst_n      : asynchronous active-low reset; flushes the FIFO, clears counter.
//   bus        : slave modport carrying xb_data/xb_valid in, m_data/m_valid out,
//                m_ready in.
//   level      : occupancy 0..DEPTH.
//   full/empty : level == DEPTH / level == 0.
//   drop_count : saturating count of dropped words.
//   drop_clr   : synchronous clear of drop_count.
// DEPTH must be a power of two >= 2; CNT_WIDTH must be <= 32.
module dtt_xbar_egress_buffer
    import dtt_xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DTT_DATA_WIDTH,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dtt_xbar_egress_buffer_if.slave   bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty,
    output logic [CNT_WIDTH-1:0]      drop_count,
    input  logic                      drop_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [31:0] CNT_MAX = 32'({CNT_WIDTH{1'b1}});

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         occupancy;
    egress_status_t        status;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Status from registered pointers only.
    always_comb begin
        occupancy    = wr_ptr_q - rd_ptr_q;
        status       = '0;
        status.level = DTT_LEVEL_W'(occupancy);
        status.empty = (wr_ptr_q == rd_ptr_q);
        status.full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    assign level      = status.level[PW-1:0];
    assign full       = status.full;
    assign empty      = status.empty;
    assign drop_count = drop_count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts the
    // incoming word when the consumer is draining; this is the only
    // combinational path from m_ready into the write side.
    always_comb begin
        pop  = !status.empty && bus.m_ready;
        push = bus.xb_valid && (!status.full || pop);
        drop = bus.xb_valid && status.full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Clear wins over a plain increment, but a drop in the clear cycle still counts.
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_clr) begin
            drop_count_d = drop ? CNT_WIDTH'(1) : '0;
        end else if (drop) begin
            drop_count_d = CNT_WIDTH'(sat_inc(32'(drop_count_q), CNT_MAX));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.xb_data;
        end
    end

    // No bypass: a word written this cycle appears after the edge.
    always_comb begin
        bus.m_valid = !status.empty;
        bus.m_data  = status.empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

endmodule

// File: doc/dtt_xbar_egress_buffer.md
# dtt_xbar_egress_buffer

Per-output egress buffer that sits directly downstream of the crossbar switch, one instance per crossbar output port. The crossbar emits at most one word per cycle per output with no backpressure. This block absorbs those words into a synchronous FIFO and drains them to the consumer over a valid/ready handshake. It counts words dropped on overflow and exposes fill-level status.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; matches the crossbar data width.
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- CNT_WIDTH, 16, drop counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- xb_data  in  DATA_WIDTH  word from the crossbar output (out_data[k]).
- xb_valid  in  1  crossbar output valid (out_valid[k]); no ready is returned.
- m_data  out  DATA_WIDTH  head-of-FIFO word.
- m_valid  out  1  head word available.
- m_ready  in  1  consumer accepts the head word this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drop_count  out  CNT_WIDTH  saturating count of dropped words.
- drop_clr  in  1  synchronous clear of drop_count.

## Operation
- **Pop.**
  - pop = m_valid && m_ready.
  - The head advances on the next edge.
- **Push.**
  - push = xb_valid && (!full || pop).
  - When the FIFO is full and a pop occurs in the same cycle, the incoming word is accepted.
- **Drop.**
  - drop = xb_valid && full && !pop.
  - The word is discarded and the FIFO is unchanged.
- **Level update.**
  - push && !pop → +1.
  - pop && !push → −1.
  - push and pop together → unchanged.
- **Pointers.**
  - Read and write pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - full: MSBs differ and the low bits are equal.
  - empty: the pointers are equal.
  - Pointers wrap naturally modulo 2·DEPTH.
- **Output.**
  - m_valid = !empty.
  - m_data = mem[rd_ptr] when non-empty, otherwise 0.
  - No bypass: a word written into an empty FIFO is not visible in the same cycle.
- **Drop counter.**
  - drop increments drop_count; the counter saturates at 2^CNT_WIDTH−1 and holds.
  - drop_clr loads 0, or 1 if drop is asserted in the same cycle.
- **Reset (asynchronous).**
  - Pointers, level and drop_count go to 0.
  - Outputs: m_valid=0, m_data=0, empty=1, full=0, level=0, drop_count=0.
  - Reset asserted mid-operation discards all contents immediately.
  - Memory contents are not reset.
- No FSM. The state is the pointer pair plus the counter.

## Timing
- Latency: xb_valid sampled at edge k gives m_valid=1 and the word on m_data after edge k (1 cycle).
- While m_valid && !m_ready, m_data and m_valid stay stable until a pop.
- Throughput: 1 word/cycle sustained when m_ready is held high.
- level, full, empty and drop_count are registered-state derived and change only after a clock edge.
- m_ready → push has a combinational path, used only for the full-with-pop case.
- First push after reset release: xb_valid at the first rising edge with rst_n=1 is accepted.

## Structure
- Shared package dtt_xbar_pkg holds:
  - DTT_DATA_WIDTH default (32), shared with the crossbar.
  - An egress_status_t struct {level, full, empty}.
  - A sat_inc function used for drop_count.
- No sub-module. Storage is an inferred register array inside this block.
- The top level instantiates N_OUT copies via generate, one per crossbar output.

## Test plan
All scenarios use DEPTH=4 and CNT_WIDTH=4.
- **Reset:** assert rst_n=0 mid-stream with 3 words queued → immediately m_valid=0, level=0, empty=1, drop_count=0, m_data=0.
- **Single word:** push 32'hAAAA_BBBB for one cycle with m_ready=0 → next cycle m_valid=1, m_data=AAAA_BBBB, level=1. Data holds for 5 cycles, then pops on m_ready=1 → empty=1.
- **Overflow:** push 6 words 1..6 with m_ready=0 → level=4, full=1, drop_count=2. Draining yields 1,2,3,4 in order.
- **Full with simultaneous pop:** while full with 1..4, push 5 with m_ready=1 → no drop, level stays 4. Drain order is 2,3,4,5.
- **Wrap-around:** stream 20 words with m_ready=1 continuously → all 20 emerge in order with 1-cycle latency, level ≤ 1, drop_count=0.
- **Counter saturation and clear:**
  - Force 20 drops → drop_count=15 and holds.
  - drop_clr together with a drop → drop_count=1.
  - drop_clr alone → 0.
